scc_access_sequencer: RTL and testbench
=======================================

// Module: scc_access_sequencer
// PURPOSE
//  Sole owner of the SCC wave-RAM req/ack port. It serialises two requesters:
//  - CPU slot accesses, which always win arbitration.
//  - An internal mirror engine that replays CPU writes to channel-4 wave RAM
//    (SCC offsets 0x60-0x7F) into channel-5 wave RAM (0x80-0x9F).
//  Sits between the cartridge mapper decode and the scc_wave core.
//  Replaces ad-hoc copy logic in mapper modules.
// PARAMETERS
//  DEPTH   4   mirror FIFO entries; power of 2, 2..16
// PORTS
//  clk          in   1   system clock (21 MHz domain)
//  reset_n      in   1   asynchronous, active-low reset
//  copy_en      in   1   1 = mirror channel-4 writes into channel 5
//  cpu_stb      in   1   one-cycle access strobe; only legal while cpu_busy=0
//  cpu_wr       in   1   1 = write, 0 = read; qualified by cpu_stb
//  cpu_addr     in   8   SCC-space address; qualified by cpu_stb
//  cpu_wdata    in   8   write data; qualified by cpu_stb
//  cpu_busy     out  1   CPU access pending or in flight
//  cpu_done     out  1   one-cycle pulse when the CPU access completes
//  cpu_rdata    out  8   read data, valid from cpu_done until the next read completes
//  scc_req      out  1   request to scc_wave; held until scc_ack
//  scc_wrt      out  1   write qualifier to scc_wave
//  scc_adr      out  8   address to scc_wave
//  scc_dbo      out  8   write data to scc_wave
//  scc_ack      in   1   scc_wave acknowledge
//  scc_dbi      in   8   scc_wave read data, valid with scc_ack
//  fifo_level   out  log2(DEPTH)+1   mirror entries queued
//  overflow     out  1   sticky: a mirror write was dropped because the FIFO was full
//  proto_err    out  1   sticky: cpu_stb was asserted while cpu_busy=1
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - state=IDLE; FIFO emptied.
//  - All outputs 0: scc_req, cpu_busy, cpu_done, cpu_rdata=0, fifo_level, overflow, proto_err.
//  Strobe capture:
//  - cpu_stb with cpu_busy=0 latches {wr,addr,wdata} into a one-entry holding register.
//  - cpu_busy=1 from the next cycle until cpu_done.
//  - cpu_stb with cpu_busy=1 is ignored and sets proto_err.
//  FSM (all outputs registered):
//  - IDLE: if the holding register is full or cpu_stb is high, go to CPU.
//    Else, if fifo_level!=0, go to COPY.
//    Else stay in IDLE.
//  - CPU: scc_req=1; scc_adr/wrt/dbo come from the holding register.
//    On scc_ack: cpu_done pulses in the next cycle; a read captures scc_dbi into cpu_rdata.
//    Holding register cleared; go to IDLE.
//  - COPY: scc_req=1, scc_wrt=1, scc_adr={3'b100,head.off}, scc_dbo=head.data.
//    On scc_ack: pop the FIFO; go to IDLE.
//  - scc_req is low for at least one cycle (IDLE) between any two transactions.
//  Latency: cpu_stb in IDLE at cycle 0 -> scc_req=1 at cycle 1.
//  - With a same-cycle ack, cpu_done=1 at cycle 2.
//  - A copy in flight delays a CPU access by at most one transaction; there is no preemption.
//  Mirror push:
//  - Occurs at scc_ack in CPU state when copy_en=1, wr=1 and addr[7:5]=3'b011.
//  - Entry is {addr[4:0], wdata}.
//  - When fifo_level=DEPTH the entry is dropped and overflow is set.
//  - Push (CPU state) and pop (COPY state) are mutually exclusive; no simultaneous case exists.
//  Ordering: FIFO order is strict; the oldest mirror write reaches channel 5 first.
//  copy_en=0 stops new pushes only; queued entries still drain.
//  Reset mid-transaction: scc_req drops immediately and the queued and pending accesses are lost.
// TESTING
//  1. Read 0x05 on idle bus, scc_ack 2 cycles after scc_req, scc_dbi=0xA5
//     -> one scc_req, scc_wrt=0, cpu_done one cycle later, cpu_rdata=0xA5, fifo_level=0.
//  2. copy_en=1, write 0x6C<=0x3E -> CPU transaction (adr 0x6C), IDLE gap,
//     then COPY transaction adr 0x8C dbo 0x3E; fifo_level returns to 0.
//  3. copy_en=1, ack withheld in COPY: five writes 0x60..0x64 (each after cpu_done)
//     -> fifo_level saturates at 4, overflow=1; release ack
//     -> channel-5 writes 0x80..0x83 in order, 0x84 never written.
//  4. CPU strobe while COPY is waiting for ack -> copy completes first, CPU next
//     (after one IDLE cycle), then remaining copies; scc_req never high two
//     transactions without a low cycle between them.
//  5. cpu_stb during cpu_busy -> second strobe ignored, proto_err=1, only one transaction issued.
//  6. Assert reset_n=0 with scc_req=1 and 2 FIFO entries
//     -> all outputs 0 immediately, fifo_level=0, no copy after release.

Source files
------------

// File: rtl/scc_access_sequencer.sv
// -----------------------------------------------------------------------------
// scc_access_sequencer
//
// Sole owner of the SCC wave-RAM req/ack port. Two requesters share it:
//   - CPU slot accesses, which always win arbitration at an idle decision point.
//   - A mirror engine that replays CPU writes to channel-4 wave RAM
//     (0x60-0x7F) into channel-5 wave RAM (0x80-0x9F) through a small FIFO.
// Transactions never preempt each other, and scc_req always drops for at
// least one IDLE cycle between two transactions.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   copy_en_i      1 = mirror channel-4 writes into channel 5
//   cpu_stb_i      one-cycle access strobe (legal only while cpu_busy_o=0)
//   cpu_wr_i       1 = write, 0 = read (qualified by cpu_stb_i)
//   cpu_addr_i     SCC-space address (qualified by cpu_stb_i)
//   cpu_wdata_i    write data (qualified by cpu_stb_i)
//   cpu_busy_o     CPU access pending or in flight
//   cpu_done_o     one-cycle pulse when the CPU access completes
//   cpu_rdata_o    read data, held until the next read completes
//   scc_req_o      request to scc_wave, held until scc_ack_i
//   scc_wrt_o      write qualifier to scc_wave
//   scc_adr_o      address to scc_wave
//   scc_dbo_o      write data to scc_wave
//   scc_ack_i      scc_wave acknowledge
//   scc_dbi_i      scc_wave read data, valid with scc_ack_i
//   fifo_level_o   number of queued mirror entries
//   overflow_o     sticky: a mirror write was dropped (FIFO full)
//   proto_err_o    sticky: cpu_stb_i seen while cpu_busy_o=1
// -----------------------------------------------------------------------------
module scc_access_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     copy_en_i,
    input  logic                     cpu_stb_i,
    input  logic                     cpu_wr_i,
    input  logic [7:0]               cpu_addr_i,
    input  logic [7:0]               cpu_wdata_i,
    output logic                     cpu_busy_o,
    output logic                     cpu_done_o,
    output logic [7:0]               cpu_rdata_o,
    output logic                     scc_req_o,
    output logic                     scc_wrt_o,
    output logic [7:0]               scc_adr_o,
    output logic [7:0]               scc_dbo_o,
    input  logic                     scc_ack_i,
    input  logic [7:0]               scc_dbi_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     proto_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        COPY
    } state_e;

    state_e state_q, state_d;

    // One-entry CPU holding register
    logic       hold_valid_q, hold_valid_d;
    logic       hold_wr_q, hold_wr_d;
    logic [7:0] hold_addr_q, hold_addr_d;
    logic [7:0] hold_wdata_q, hold_wdata_d;

    // Registered outputs
    logic       req_q, req_d;
    logic       wrt_q, wrt_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] dbo_q, dbo_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ovf_q, ovf_d;
    logic       proto_q, proto_d;

    // Mirror FIFO: entry = {channel-4 offset[4:0], data[7:0]}
    logic [12:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [12:0]   head;

    assign head = mem_q[rd_ptr_q];

    // Next-state logic for the FSM, holding register, outputs and FIFO control.
    // The IDLE branch forwards the strobe fields directly so that a strobe in
    // IDLE produces scc_req on the very next cycle.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_wr_d    = hold_wr_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        req_d        = req_q;
        wrt_d        = wrt_q;
        adr_d        = adr_q;
        dbo_d        = dbo_q;
        done_d       = 1'b0;
        rdata_d      = rdata_q;
        ovf_d        = ovf_q;
        proto_d      = proto_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (cpu_stb_i) begin
            if (hold_valid_q) begin
                proto_d = 1'b1;
            end else begin
                hold_valid_d = 1'b1;
                hold_wr_d    = cpu_wr_i;
                hold_addr_d  = cpu_addr_i;
                hold_wdata_d = cpu_wdata_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q || cpu_stb_i) begin
                    state_d = CPU;
                    req_d   = 1'b1;
                    wrt_d   = hold_valid_q ? hold_wr_q    : cpu_wr_i;
                    adr_d   = hold_valid_q ? hold_addr_q  : cpu_addr_i;
                    dbo_d   = hold_valid_q ? hold_wdata_q : cpu_wdata_i;
                end else if (count_q != '0) begin
                    state_d = COPY;
                    req_d   = 1'b1;
                    wrt_d   = 1'b1;
                    adr_d   = {3'b100, head[12:8]};
                    dbo_d   = head[7:0];
                end
            end
            CPU: begin
                if (scc_ack_i) begin
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    done_d       = 1'b1;
                    hold_valid_d = 1'b0;
                    if (!hold_wr_q) begin
                        rdata_d = scc_dbi_i;
                    end
                    if (copy_en_i && hold_wr_q && (hold_addr_q[7:5] == 3'b011)) begin
                        if (count_q == FULL_LEVEL) begin
                            ovf_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            end
            COPY: begin
                if (scc_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    pop     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // FIFO pointer and level bookkeeping; push and pop never coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // State and output registers; reset drops scc_req immediately and
    // discards pending and queued work.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= 8'h00;
            hold_wdata_q <= 8'h00;
            req_q        <= 1'b0;
            wrt_q        <= 1'b0;
            adr_q        <= 8'h00;
            dbo_q        <= 8'h00;
            done_q       <= 1'b0;
            rdata_q      <= 8'h00;
            ovf_q        <= 1'b0;
            proto_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_wr_q    <= hold_wr_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            req_q        <= req_d;
            wrt_q        <= wrt_d;
            adr_q        <= adr_d;
            dbo_q        <= dbo_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            ovf_q        <= ovf_d;
            proto_q      <= proto_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage needs no reset: the pointers alone define valid entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {hold_addr_q[4:0], hold_wdata_q};
        end
    end

    assign cpu_busy_o   = hold_valid_q;
    assign cpu_done_o   = done_q;
    assign cpu_rdata_o  = rdata_q;
    assign scc_req_o    = req_q;
    assign scc_wrt_o    = wrt_q;
    assign scc_adr_o    = adr_q;
    assign scc_dbo_o    = dbo_q;
    assign fifo_level_o = count_q;
    assign overflow_o   = ovf_q;
    assign proto_err_o  = proto_q;

endmodule

// File: tb/tb_scc_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scc_access_sequencer
//
// Randomised bench for scc_access_sequencer. A transaction-level reference
// model (pending CPU access, current bus transaction, mirror queue) predicts
// every registered output each cycle. Phases cover mixed random traffic,
// back-to-back mirror writes that overflow the FIFO, draining with copy
// disabled, illegal strobes, and an asynchronous reset in mid-transaction.
// -----------------------------------------------------------------------------
module tb_scc_access_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       resetN;
    logic       copyEn;
    logic       cpuStb;
    logic       cpuWr;
    logic [7:0] cpuAddr;
    logic [7:0] cpuWdata;
    logic       cpuBusy;
    logic       cpuDone;
    logic [7:0] cpuRdata;
    logic       sccReq;
    logic       sccWrt;
    logic [7:0] sccAdr;
    logic [7:0] sccDbo;
    logic       sccAck;
    logic [7:0] sccDbi;
    logic [2:0] fifoLevel;
    logic       overflow;
    logic       protoErr;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [12:0] mq[$];
    bit          mPend;
    logic        mPendWr;
    logic [7:0]  mPendAddr;
    logic [7:0]  mPendData;
    bit          mTxn;
    bit          mTxnCpu;
    logic        mTxnWr;
    logic [7:0]  mTxnAdr;
    logic [7:0]  mTxnDbo;
    bit          mDone;
    bit          mOvf;
    bit          mProto;
    logic [7:0]  mRdata;

    scc_access_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_n_i    (resetN),
        .copy_en_i    (copyEn),
        .cpu_stb_i    (cpuStb),
        .cpu_wr_i     (cpuWr),
        .cpu_addr_i   (cpuAddr),
        .cpu_wdata_i  (cpuWdata),
        .cpu_busy_o   (cpuBusy),
        .cpu_done_o   (cpuDone),
        .cpu_rdata_o  (cpuRdata),
        .scc_req_o    (sccReq),
        .scc_wrt_o    (sccWrt),
        .scc_adr_o    (sccAdr),
        .scc_dbo_o    (sccDbo),
        .scc_ack_i    (sccAck),
        .scc_dbi_i    (sccDbi),
        .fifo_level_o (fifoLevel),
        .overflow_o   (overflow),
        .proto_err_o  (protoErr)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Clears the model to its post-reset picture
    task automatic resetModel();
        mq.delete();
        mPend   = 0;
        mPendWr = 1'b0;
        mPendAddr = 8'h00;
        mPendData = 8'h00;
        mTxn    = 0;
        mTxnCpu = 0;
        mTxnWr  = 1'b0;
        mTxnAdr = 8'h00;
        mTxnDbo = 8'h00;
        mDone   = 0;
        mOvf    = 0;
        mProto  = 0;
        mRdata  = 8'h00;
    endtask

    // Advances the model by one clock edge using the inputs held during the
    // cycle that just ended. A new transaction starts only from an idle cycle,
    // CPU work first, mirror queue second.
    task automatic modelStep();
        bit          busyBefore;
        logic [12:0] headEntry;
        busyBefore = mPend;
        mDone = 0;
        if (cpuStb) begin
            if (!busyBefore) begin
                mPend     = 1;
                mPendWr   = cpuWr;
                mPendAddr = cpuAddr;
                mPendData = cpuWdata;
            end else begin
                mProto = 1;
            end
        end
        if (mTxn) begin
            if (sccAck) begin
                if (mTxnCpu) begin
                    mDone = 1;
                    mPend = 0;
                    if (!mTxnWr) begin
                        mRdata = sccDbi;
                    end else if (copyEn && mTxnAdr >= 8'h60 && mTxnAdr <= 8'h7F) begin
                        if (mq.size() < DEPTH) mq.push_back({mTxnAdr[4:0], mTxnDbo});
                        else mOvf = 1;
                    end
                end else begin
                    void'(mq.pop_front());
                end
                mTxn = 0;
            end
        end else if (mPend) begin
            mTxn    = 1;
            mTxnCpu = 1;
            mTxnWr  = mPendWr;
            mTxnAdr = mPendAddr;
            mTxnDbo = mPendData;
        end else if (mq.size() != 0) begin
            headEntry = mq[0];
            mTxn    = 1;
            mTxnCpu = 0;
            mTxnWr  = 1'b1;
            mTxnAdr = 8'h80 + {3'b000, headEntry[12:8]};
            mTxnDbo = headEntry[7:0];
        end
    endtask

    // Compares every visible output with the model
    task automatic compareAll();
        checkOutput("scc_req", {15'd0, sccReq}, {15'd0, mTxn});
        checkOutput("cpu_busy", {15'd0, cpuBusy}, {15'd0, mPend});
        checkOutput("cpu_done", {15'd0, cpuDone}, {15'd0, mDone});
        checkOutput("cpu_rdata", {8'd0, cpuRdata}, {8'd0, mRdata});
        checkOutput("fifo_level", {13'd0, fifoLevel}, 16'(mq.size()));
        checkOutput("overflow", {15'd0, overflow}, {15'd0, mOvf});
        checkOutput("proto_err", {15'd0, protoErr}, {15'd0, mProto});
        if (mTxn) begin
            checkOutput("scc_wrt", {15'd0, sccWrt}, {15'd0, mTxnWr});
            checkOutput("scc_adr", {8'd0, sccAdr}, {8'd0, mTxnAdr});
            if (mTxnWr) checkOutput("scc_dbo", {8'd0, sccDbo}, {8'd0, mTxnDbo});
        end
    endtask

    // Drives random traffic for a number of cycles. Entered and left at
    // posedge+1. copyMode: 0/1 fixed, 2 random per cycle. mirrorOnly forces
    // writes into the channel-4 window.
    task automatic applyStimulus(input int stbPct, input int ackPct, input int illegalPct,
                                 input int copyMode, input bit mirrorOnly, input int nCycles);
        for (int c = 0; c < nCycles; c++) begin
            copyEn   = (copyMode == 2) ? 1'($urandom_range(0, 1)) : 1'(copyMode);
            cpuStb   = mPend ? ($urandom_range(0, 99) < illegalPct)
                             : ($urandom_range(0, 99) < stbPct);
            cpuWdata = 8'($urandom);
            if (mirrorOnly) begin
                cpuWr   = 1'b1;
                cpuAddr = 8'h60 + 8'($urandom_range(0, 31));
            end else begin
                cpuWr   = 1'($urandom_range(0, 1));
                cpuAddr = ($urandom_range(0, 1) == 1) ? 8'h60 + 8'($urandom_range(0, 31))
                                                      : 8'($urandom);
            end
            sccAck = mTxn && ($urandom_range(0, 99) < ackPct);
            sccDbi = 8'($urandom);
            @(posedge clk);
            modelStep();
            #1;
            compareAll();
        end
    endtask

    task automatic clearInputs();
        copyEn   = 1'b0;
        cpuStb   = 1'b0;
        cpuWr    = 1'b0;
        cpuAddr  = 8'h00;
        cpuWdata = 8'h00;
        sccAck   = 1'b0;
        sccDbi   = 8'h00;
    endtask

    initial begin
        bit reached;
        resetN = 1'b0;
        clearInputs();
        resetModel();
        #1;
        $display("[TB] reset state");
        compareAll();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] mixed random traffic");
        applyStimulus(40, 40, 0, 2, 0, 800);

        $display("[TB] back-to-back mirror writes");
        applyStimulus(100, 100, 0, 1, 1, 40);
        checkOutput("overflowSticky", {15'd0, overflow}, 16'd1);

        $display("[TB] drain with copy disabled");
        applyStimulus(0, 100, 0, 0, 0, 20);
        checkOutput("drainedLevel", {13'd0, fifoLevel}, 16'd0);

        $display("[TB] illegal strobes");
        applyStimulus(50, 50, 30, 2, 0, 300);
        checkOutput("protoSticky", {15'd0, protoErr}, 16'd1);
        applyStimulus(0, 100, 0, 0, 0, 20);

        $display("[TB] reset during transaction");
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            applyStimulus(100, 100, 0, 1, 1, 1);
            if (mq.size() == 2 && mTxn) reached = 1;
        end
        checkOutput("resetSetupReached", {15'd0, reached}, 16'd1);
        checkOutput("reqBeforeReset", {15'd0, sccReq}, 16'd1);
        #3;
        resetN = 1'b0;
        clearInputs();
        resetModel();
        #1;
        compareAll();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 12);
        checkOutput("postResetLevel", {13'd0, fifoLevel}, 16'd0);

        $display("[TB] random traffic after reset");
        applyStimulus(30, 60, 0, 2, 0, 200);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
